// File: rtl/spi_pkg.sv
// ----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master/slave harness.
//   state_e     : master FSM states (IDLE, LOAD, XFER, DONE)
//   spi_cpol    : SCLK idle level taken from a 2-bit SPI mode
//   spi_cpha    : sampling phase taken from a 2-bit SPI mode
//   HALF_CNT_W  : width of the SCLK half-period counter; it must hold
//                 2*bits_num for the largest legal word (32 bits)
// ----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        XFER,
        DONE
    } state_e;

    localparam int unsigned MAX_BITS   = 32;
    localparam int unsigned HALF_CNT_W = $clog2(2 * MAX_BITS + 1);

    function automatic logic spi_cpol(input logic [1:0] m);
        return m[1];
    endfunction

    function automatic logic spi_cpha(input logic [1:0] m);
        return m[0];
    endfunction

endpackage

// File: rtl/spi_slave.sv
// ----------------------------------------------------------------------------
// spi_slave
// Clock-domain SPI slave: detects SCLK edges from a registered copy of SCLK,
// shifts its word out on MISO, shifts MOSI in, and latches the received word
// when its slave-select is released.
// Optional build macro: SPI_LSB_FIRST_EN (shift LSB first instead of MSB).
// Ports:
//   i_clk, i_rst_n : system clock, async active-low reset
//   i_sclk, i_mosi : bus clock and master-out data
//   i_ss_n         : active-low slave select
//   i_data         : word returned to the master (loaded at select)
//   o_miso         : slave-out data
//   o_data         : last word received from the master
// ----------------------------------------------------------------------------
module spi_slave
    import spi_pkg::*;
#(
    parameter logic [1:0]  mode     = 2'b11,
    parameter int unsigned bits_num = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_sclk,
    input  logic                i_mosi,
    input  logic                i_ss_n,
    input  logic [bits_num-1:0] i_data,
    output logic                o_miso,
    output logic [bits_num-1:0] o_data
);

    localparam logic CPOL = spi_cpol(mode);
    localparam logic CPHA = spi_cpha(mode);

    logic                r_sclk_q;
    logic                r_ss_q;
    logic                r_miso;
    logic [bits_num-1:0] r_tx;
    logic [bits_num-1:0] r_rx;
    logic [bits_num-1:0] r_data;

    logic                w_ss_fall;
    logic                w_ss_rise;
    logic                w_edge;
    logic                w_lead;
    logic                w_sample;
    logic                w_shift;
    logic [bits_num-1:0] w_src;
    logic                w_src_bit;
    logic [bits_num-1:0] w_src_next;
    logic [bits_num-1:0] w_rx_next;

    assign w_ss_fall = ~i_ss_n & r_ss_q;
    assign w_ss_rise = i_ss_n & ~r_ss_q;
    // Edges are seen one clk after the master moves SCLK; leading = leaving idle
    assign w_edge    = ~i_ss_n & (i_sclk ^ r_sclk_q);
    assign w_lead    = (i_sclk != CPOL);
    assign w_sample  = w_edge & (w_lead ^ CPHA);
    assign w_shift   = w_edge & ~(w_lead ^ CPHA);
    // At select the first bit comes straight from i_data
    assign w_src     = w_ss_fall ? i_data : r_tx;

    always_comb begin
`ifdef SPI_LSB_FIRST_EN
        w_src_bit  = w_src[0];
        w_src_next = {1'b0, w_src[bits_num-1:1]};
        w_rx_next  = {i_mosi, r_rx[bits_num-1:1]};
`else
        w_src_bit  = w_src[bits_num-1];
        w_src_next = {w_src[bits_num-2:0], 1'b0};
        w_rx_next  = {r_rx[bits_num-2:0], i_mosi};
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sclk_q <= CPOL;
            r_ss_q   <= 1'b1;
            r_miso   <= 1'b0;
            r_tx     <= '0;
            r_rx     <= '0;
            r_data   <= '0;
        end else begin
            r_sclk_q <= i_sclk;
            r_ss_q   <= i_ss_n;
            if (w_ss_fall) begin
                if (CPHA) begin
                    r_tx <= i_data;
                end else begin
                    r_miso <= w_src_bit;
                    r_tx   <= w_src_next;
                end
            end else if (w_shift) begin
                r_miso <= w_src_bit;
                r_tx   <= w_src_next;
            end
            if (w_sample) begin
                r_rx <= w_rx_next;
            end
            if (w_ss_rise) begin
                r_data <= r_rx;
            end
        end
    end

    assign o_miso = r_miso;
    assign o_data = r_data;

endmodule

// File: rtl/spi_top.sv
// ----------------------------------------------------------------------------
// spi_top
// One SPI master and four spi_slave instances on an internal bus. A tx_start
// pulse runs one full-duplex bits_num-bit exchange with the slave picked by
// sel; tx_end pulses for one clk when both sides hold their received words.
// Optional build macro: SPI_LSB_FIRST_EN (LSB-first wire order).
// Ports:
//   clk, reset                     : system clock, async active-low reset
//   tx_start, sel                  : start pulse, target slave (0..3)
//   master_data_in                 : word sent by the master
//   slave1..4_data_in              : words returned by each slave
//   tx_end                         : one-cycle completion pulse
//   master_data_out                : last word received by the master
//   slave1..4_data_out             : last word received by each slave
// ----------------------------------------------------------------------------
module spi_top
    import spi_pkg::*;
#(
    parameter logic [1:0]  mode        = 2'b11,
    parameter int unsigned bits_num    = 8,
    parameter int unsigned HALF_PERIOD = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tx_start,
    input  logic [1:0]          sel,
    input  logic [bits_num-1:0] master_data_in,
    input  logic [bits_num-1:0] slave1_data_in,
    input  logic [bits_num-1:0] slave2_data_in,
    input  logic [bits_num-1:0] slave3_data_in,
    input  logic [bits_num-1:0] slave4_data_in,
    output logic                tx_end,
    output logic [bits_num-1:0] master_data_out,
    output logic [bits_num-1:0] slave1_data_out,
    output logic [bits_num-1:0] slave2_data_out,
    output logic [bits_num-1:0] slave3_data_out,
    output logic [bits_num-1:0] slave4_data_out
);

    localparam logic                  CPOL     = spi_cpol(mode);
    localparam logic                  CPHA     = spi_cpha(mode);
    localparam int unsigned           HP_W     = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [HP_W-1:0]       HP_LAST  = HP_W'(HALF_PERIOD - 1);
    localparam logic [HALF_CNT_W-1:0] HALF_END = HALF_CNT_W'(2 * bits_num);

    state_e                r_state;
    logic [1:0]            r_sel;
    logic [3:0]            r_ss_n;
    logic                  r_sclk;
    logic                  r_mosi;
    logic [HP_W-1:0]       r_cnt;
    logic [HALF_CNT_W-1:0] r_half;
    logic                  r_samp_pend;
    logic [bits_num-1:0]   r_tx;
    logic [bits_num-1:0]   r_rx;
    logic [bits_num-1:0]   r_mdo;
    logic                  r_tx_end;

    logic                  w_sclk;
    logic                  w_miso;
    logic                  w_toggle;
    logic                  w_sample_edge;
    logic                  w_tx_bit;
    logic [bits_num-1:0]   w_tx_next;
    logic [bits_num-1:0]   w_rx_next;
    logic [bits_num-1:0]   w_sl_din  [4];
    logic [bits_num-1:0]   w_sl_dout [4];
    logic                  w_sl_miso [4];

    assign w_sclk        = r_sclk;
    assign w_miso        = w_sl_miso[r_sel];
    assign w_toggle      = (r_state == XFER) && (r_half != HALF_END) && (r_cnt == HP_LAST);
    // Even half-periods end on a leading edge
    assign w_sample_edge = ~r_half[0] ^ CPHA;

    always_comb begin
`ifdef SPI_LSB_FIRST_EN
        w_tx_bit  = r_tx[0];
        w_tx_next = {1'b0, r_tx[bits_num-1:1]};
        w_rx_next = {w_miso, r_rx[bits_num-1:1]};
`else
        w_tx_bit  = r_tx[bits_num-1];
        w_tx_next = {r_tx[bits_num-2:0], 1'b0};
        w_rx_next = {r_rx[bits_num-2:0], w_miso};
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_sel       <= 2'd0;
            r_ss_n      <= 4'hF;
            r_sclk      <= CPOL;
            r_mosi      <= 1'b0;
            r_cnt       <= '0;
            r_half      <= '0;
            r_samp_pend <= 1'b0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_mdo       <= '0;
            r_tx_end    <= 1'b0;
        end else begin
            r_tx_end <= 1'b0;
            // MISO is sampled one clk after the edge, matching the slaves'
            // registered edge detect so every HALF_PERIOD >= 1 has margin
            r_samp_pend <= w_toggle & w_sample_edge;
            if (r_samp_pend) begin
                r_rx <= w_rx_next;
            end
            case (r_state)
                IDLE: begin
                    if (tx_start) begin
                        r_sel   <= sel;
                        r_tx    <= master_data_in;
                        r_ss_n  <= ~(4'b0001 << sel);
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (!CPHA) begin
                        r_mosi <= w_tx_bit;
                        r_tx   <= w_tx_next;
                    end
                    r_cnt   <= '0;
                    r_half  <= '0;
                    r_state <= XFER;
                end
                XFER: begin
                    // One settle cycle after the last SCLK edge lets the
                    // slaves finish their final sample before select drops
                    if (r_half == HALF_END) begin
                        r_ss_n   <= 4'hF;
                        r_tx_end <= 1'b1;
                        r_state  <= DONE;
                    end else if (r_cnt == HP_LAST) begin
                        r_cnt  <= '0;
                        r_half <= r_half + 1'b1;
                        r_sclk <= ~r_sclk;
                        if (!w_sample_edge) begin
                            r_mosi <= w_tx_bit;
                            r_tx   <= w_tx_next;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_mdo   <= r_rx;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_sl_din[0] = slave1_data_in;
    assign w_sl_din[1] = slave2_data_in;
    assign w_sl_din[2] = slave3_data_in;
    assign w_sl_din[3] = slave4_data_in;

    for (genvar g = 0; g < 4; g++) begin : g_slave
        spi_slave #(
            .mode     (mode),
            .bits_num (bits_num)
        ) u_slave (
            .i_clk   (clk),
            .i_rst_n (reset),
            .i_sclk  (r_sclk),
            .i_mosi  (r_mosi),
            .i_ss_n  (r_ss_n[g]),
            .i_data  (w_sl_din[g]),
            .o_miso  (w_sl_miso[g]),
            .o_data  (w_sl_dout[g])
        );
    end

    assign tx_end          = r_tx_end;
    assign master_data_out = r_mdo;
    assign slave1_data_out = w_sl_dout[0];
    assign slave2_data_out = w_sl_dout[1];
    assign slave3_data_out = w_sl_dout[2];
    assign slave4_data_out = w_sl_dout[3];

endmodule

// File: tb/tb_spi_top.sv
// ----------------------------------------------------------------------------
// tb_spi_top
// Runs four spi_top instances (modes 0..3) from shared stimulus. A
// transaction-level model predicts tx_end timing and the swapped words; every
// cycle all instances are compared against it, and directed literal checks
// pin latency, pulse width and the exchanged words.
// ----------------------------------------------------------------------------
module tb_spi_top;

    localparam int unsigned N   = 8;
    localparam int unsigned LAT = 34;

    logic         clk      = 1'b0;
    logic         reset    = 1'b0;
    logic         tx_start = 1'b0;
    logic [1:0]   sel      = 2'd0;
    logic [N-1:0] mdi      = '0;
    logic [N-1:0] sdi      [4];

    logic         tx_end_m [4];
    logic [N-1:0] mdo      [4];
    logic [N-1:0] sdo      [4][4];
    logic         sclk_m   [4];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_top #(
            .mode        (2'(g)),
            .bits_num    (N),
            .HALF_PERIOD (2)
        ) u_dut (
            .clk             (clk),
            .reset           (reset),
            .tx_start        (tx_start),
            .sel             (sel),
            .master_data_in  (mdi),
            .slave1_data_in  (sdi[0]),
            .slave2_data_in  (sdi[1]),
            .slave3_data_in  (sdi[2]),
            .slave4_data_in  (sdi[3]),
            .tx_end          (tx_end_m[g]),
            .master_data_out (mdo[g]),
            .slave1_data_out (sdo[g][0]),
            .slave2_data_out (sdo[g][1]),
            .slave3_data_out (sdo[g][2]),
            .slave4_data_out (sdo[g][3])
        );
        assign sclk_m[g] = u_dut.w_sclk;
    end

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d] actual=0x%0h required=0x%0h", name, idx, act, exp);
    endtask

    // Transaction model: accept when idle, swap words, tx_end LAT edges later,
    // outputs refreshed on the following edge.
    logic              m_busy;
    int unsigned       m_cnt;
    logic [1:0]        m_sel;
    logic [N-1:0]      m_mword;
    logic [N-1:0]      m_sword;
    logic [N-1:0]      m_mdo;
    logic [N-1:0]      m_sdo [4];
    logic              m_tx_end;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy   <= 1'b0;
            m_cnt    <= 0;
            m_sel    <= 2'd0;
            m_mword  <= '0;
            m_sword  <= '0;
            m_mdo    <= '0;
            m_tx_end <= 1'b0;
            for (int i = 0; i < 4; i++) m_sdo[i] <= '0;
        end else begin
            m_tx_end <= 1'b0;
            if (!m_busy) begin
                if (tx_start) begin
                    m_busy  <= 1'b1;
                    m_cnt   <= 1;
                    m_sel   <= sel;
                    m_mword <= mdi;
                end
            end else begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == 1) m_sword <= sdi[m_sel];
                if (m_cnt == LAT) m_tx_end <= 1'b1;
                if (m_cnt == LAT + 1) begin
                    m_mdo        <= m_sword;
                    m_sdo[m_sel] <= m_mword;
                    m_busy       <= 1'b0;
                end
            end
        end
    end

    // Per-cycle compare of every instance against the model
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int m = 0; m < 4; m++) begin
                check("tx_end", m, 32'(tx_end_m[m]), 32'(m_tx_end));
                check("master_data_out", m, 32'(mdo[m]), 32'(m_mdo));
                for (int s = 0; s < 4; s++)
                    check("slave_data_out", m * 4 + s, 32'(sdo[m][s]), 32'(m_sdo[s]));
                if (!m_busy) check("sclk_idle", m, 32'(sclk_m[m]), 32'(m / 2));
            end
        end
    end

    task automatic run_xfer(input logic [1:0] s, output int lat);
        @(negedge clk);
        sel      = s;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        lat      = 0;
        while (!tx_end_m[3] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Four transfers sel=0..3 with the given words, literal checks on each
    task automatic do_set(input logic [N-1:0] mw, input logic [31:0] sw);
        int lat;
        @(negedge clk);
        mdi = mw;
        for (int i = 0; i < 4; i++) sdi[i] = sw[8*i +: 8];
        for (int s = 0; s < 4; s++) begin
            run_xfer(2'(s), lat);
            check("latency", s, 32'(lat), 32'(LAT));
            @(negedge clk);
            check("tx_end_width", s, 32'(tx_end_m[3]), 32'd0);
            repeat (200 - LAT - 2) @(negedge clk);
            check("model_mdo", s, 32'(m_mdo), 32'(sw[8*s +: 8]));
            for (int m = 0; m < 4; m++) begin
                check("word_to_master", m, 32'(mdo[m]), 32'(sw[8*s +: 8]));
                check("word_to_slave", m, 32'(sdo[m][s]), 32'(mw));
            end
        end
    endtask

    initial begin
        int lat;
        int pulses;
        for (int i = 0; i < 4; i++) sdi[i] = '0;
        repeat (3) @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            check("reset_mdo", m, 32'(mdo[m]), 32'd0);
            check("reset_tx_end", m, 32'(tx_end_m[m]), 32'd0);
            check("reset_sclk", m, 32'(sclk_m[m]), 32'(m / 2));
        end
        #2 reset = 1'b1;

        // Scenario 1: master 0xAB, slaves C8/2A/F5/B9 (all four modes)
        do_set(8'hAB, {8'hB9, 8'hF5, 8'h2A, 8'hC8});

        // Second start 5 cycles after the first is ignored
        @(negedge clk);
        sel      = 2'd2;
        tx_start = 1'b1;
        lat      = -1;
        pulses   = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            tx_start = (c == 4);
            if (tx_end_m[3]) begin
                pulses++;
                if (lat < 0) lat = c;
            end
        end
        check("ignored_start_pulses", 0, 32'(pulses), 32'd1);
        check("ignored_start_latency", 0, 32'(lat), 32'(LAT));

        // Reset half-way through XFER aborts the transfer
        @(negedge clk);
        sel      = 2'd3;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (17) @(negedge clk);
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            check("abort_mdo", m, 32'(mdo[m]), 32'd0);
            check("abort_sdo1", m, 32'(sdo[m][0]), 32'd0);
            check("abort_sclk", m, 32'(sclk_m[m]), 32'(m / 2));
        end
        #2 reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (tx_end_m[3]) pulses++;
        end
        check("abort_no_tx_end", 0, 32'(pulses), 32'd0);
        run_xfer(2'd1, lat);
        check("post_abort_latency", 0, 32'(lat), 32'(LAT));
        repeat (3) @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            check("post_abort_mdo", m, 32'(mdo[m]), 32'h2A);
            check("post_abort_sdo2", m, 32'(sdo[m][1]), 32'hAB);
            check("post_abort_sdo1", m, 32'(sdo[m][0]), 32'h00);
        end
        repeat (20) @(negedge clk);

        // Scenario 2: master 0x29, slaves 92/0D/FE/1E
        do_set(8'h29, {8'h1E, 8'hFE, 8'h0D, 8'h92});

        // Boundary words
        do_set(8'h00, {8'hFF, 8'hFF, 8'hFF, 8'hFF});
        do_set(8'hFF, {8'h00, 8'h00, 8'h00, 8'h00});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation did not finish");
    end

endmodule
